// File: rtl/square_pkg.sv
// Shared settings for the square block: default width, counter width helper and FSM state type.
package package_settings;

    localparam int unsigned SIZE_DATA = 16;

    // Width needed to count from 0 up to and including n.
    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned SIZE_COUNT = count_width(SIZE_DATA);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } square_state_t;

endpackage

// File: rtl/square.sv
// Iterative unsigned squarer with saturated SIZE_DATA-bit result and valid/ready handshakes.
// One multiplier bit is consumed per clock, LSB first, into a 2*SIZE_DATA-bit accumulator.
// Optional feature macro SQUARE_EARLY_EXIT_EN: leave BUSY once the remaining multiplier bits
// are all zero. Results are identical in both builds; only latency changes.
module square #(
    parameter int unsigned SIZE_DATA = package_settings::SIZE_DATA
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 input_valid,
    output logic                 input_ready,
    input  logic [SIZE_DATA-1:0] input_data,
    output logic                 output_valid,
    input  logic                 output_ready,
    output logic [SIZE_DATA-1:0] output_data,
    output logic                 overflow
);

    // Same value as package_settings::SIZE_COUNT at the default width, but tracks overrides.
    localparam int unsigned SIZE_COUNT = package_settings::count_width(SIZE_DATA);
    localparam int unsigned ACC_W      = 2 * SIZE_DATA;

    package_settings::square_state_t state_q, state_d;

    logic [SIZE_COUNT-1:0] count_q, count_d;
    logic [ACC_W-1:0]      mcand_q, mcand_d;
    logic [SIZE_DATA-1:0]  mplier_q, mplier_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [SIZE_DATA-1:0]  out_data_q, out_data_d;
    logic                  ovf_q, ovf_d;
    logic                  started_q;

    logic [ACC_W-1:0]      acc_sum;
    logic                  last_step;
    logic                  accept;

    assign input_ready  = started_q && (state_q == package_settings::IDLE);
    assign output_valid = (state_q == package_settings::DONE);
    assign output_data  = out_data_q;
    assign overflow     = ovf_q;
    assign accept       = input_valid && input_ready;

    // Shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
        last_step = (count_q == SIZE_COUNT'(SIZE_DATA - 1));
`ifdef SQUARE_EARLY_EXIT_EN
        if ((mplier_q >> 1) == '0) begin
            last_step = 1'b1;
        end
`endif
    end

    // Next-state logic for the FSM and datapath registers.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            package_settings::IDLE: begin
                if (accept) begin
                    state_d  = package_settings::BUSY;
                    mcand_d  = {{SIZE_DATA{1'b0}}, input_data};
                    mplier_d = input_data;
                    acc_d    = '0;
                    count_d  = '0;
                end
            end
            package_settings::BUSY: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + SIZE_COUNT'(1);
                if (last_step) begin
                    state_d = package_settings::DONE;
                    // Saturate: any bit above the result width means the square does not fit.
                    if (acc_sum[ACC_W-1:SIZE_DATA] == '0) begin
                        out_data_d = acc_sum[SIZE_DATA-1:0];
                        ovf_d      = 1'b0;
                    end else begin
                        out_data_d = '1;
                        ovf_d      = 1'b1;
                    end
                end
            end
            package_settings::DONE: begin
                if (output_valid && output_ready) begin
                    state_d = package_settings::IDLE;
                end
            end
            default: begin
                state_d = package_settings::IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= package_settings::IDLE;
            count_q    <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            ovf_q      <= ovf_d;
        end
    end

    // Holds input_ready low until the first clock edge after reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started_q <= 1'b0;
        end else begin
            started_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_square.sv
// Directed self-checking bench for square at SIZE_DATA=16, both with and without
// SQUARE_EARLY_EXIT_EN (expected latencies switch with the macro).
module tb_square;

    logic        clk;
    logic        reset;
    logic        input_valid;
    logic        input_ready;
    logic [15:0] input_data;
    logic        output_valid;
    logic        output_ready;
    logic [15:0] output_data;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    square #(.SIZE_DATA(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Latency counts cycles from the accept cycle (1) to the first cycle with output_valid.
    task automatic wait_result(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) input_valid = 1'b0;
        end while (!output_valid && lat < 40);
        chk({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic offer(input logic [15:0] op);
        @(negedge clk);
        input_valid = 1'b1;
        input_data  = op;
    endtask

    task automatic handoff();
        output_ready = 1'b1;
        @(negedge clk);
        output_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [15:0] op, input logic [15:0] exp_data,
                       input logic exp_ovf, input int lat_fixed, input int lat_early);
        offer(op);
        chk({tag, "_ready"}, input_ready, 1);
`ifdef SQUARE_EARLY_EXIT_EN
        wait_result(tag, lat_early);
`else
        wait_result(tag, lat_fixed);
`endif
        chk({tag, "_data"}, output_data, exp_data);
        chk({tag, "_ovf"}, overflow, exp_ovf);
        handoff();
    endtask

    initial begin
        int seen;
        reset        = 1'b0;
        input_valid  = 1'b0;
        input_data   = '0;
        output_ready = 1'b0;

        // Reset state, including across clock edges while reset is held.
        #3;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", input_ready, 0);
        chk("rst_valid", output_valid, 0);
        chk("rst_data", output_data, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_ready_before_edge", input_ready, 0);
        @(negedge clk);
        chk("rel_ready_after_edge", input_ready, 1);

        // Main function: name, operand, square, overflow, fixed latency, early-exit latency.
        run("sq3", 16'd3, 16'd9, 1'b0, 17, 3);
        run("sq255", 16'd255, 16'd65025, 1'b0, 17, 9);
        run("sq256", 16'd256, 16'd65535, 1'b1, 17, 10);
        run("sq65535", 16'd65535, 16'd65535, 1'b1, 17, 17);
        run("sq0", 16'd0, 16'd0, 1'b0, 17, 2);
        run("sq5", 16'd5, 16'd25, 1'b0, 17, 4);
        run("sq40000", 16'd40000, 16'd65535, 1'b1, 17, 17);

        // Back-pressure in DONE while a new operand 7 is offered.
        offer(16'd12);
`ifdef SQUARE_EARLY_EXIT_EN
        wait_result("stall12", 5);
`else
        wait_result("stall12", 17);
`endif
        input_valid = 1'b1;
        input_data  = 16'd7;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!output_valid || input_ready || output_data !== 16'd144 || overflow) seen++;
        end
        chk("stall_hold_bad_cycles", seen, 0);
        chk("stall_data", output_data, 144);
        output_ready = 1'b1;
        @(negedge clk);
        output_ready = 1'b0;
        chk("post_handoff_valid", output_valid, 0);
        chk("post_handoff_ready", input_ready, 1);
`ifdef SQUARE_EARLY_EXIT_EN
        wait_result("stall7", 4);
`else
        wait_result("stall7", 17);
`endif
        chk("stall7_data", output_data, 49);
        chk("stall7_ovf", overflow, 0);
        handoff();

        // Reset pulsed at BUSY iteration 5 discards the operation.
        offer(16'd100);
        @(posedge clk);
        #1;
        input_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", input_ready, 0);
        chk("mid_rst_valid", output_valid, 0);
        chk("mid_rst_data", output_data, 0);
        chk("mid_rst_ovf", overflow, 0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (output_valid) seen++;
        end
        chk("mid_rst_no_valid", seen, 0);
        run("sq4", 16'd4, 16'd16, 1'b0, 17, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
